// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA copy engine and core/external bus arbiter (FF46-triggered 160-byte copy).
// Optional OAM_DMA_ECHO_FOLD_EN folds source pages 0xE0..0xFF onto WRAM 0xC0..0xDF.
module oam_dma_ctrl (
  input  logic        CLK,
  input  logic        SYNC_RESET,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  output logic [7:0]  CPU_DI,
  output logic [15:0] BUS_A,
  output logic        BUS_RD,
  output logic        BUS_WR,
  input  logic [7:0]  BUS_DI,
  output logic        HI_RD,
  output logic        HI_WR,
  input  logic [7:0]  HI_DI,
  output logic [7:0]  OAM_A,
  output logic [7:0]  OAM_D,
  output logic        OAM_WE,
  output logic        DMA_ACTIVE
);
  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;
  state_t     state_q;
  logic [7:0] src_q, idx_q, oam_a_q, data_q, src_eff;
  logic       pend_q, reg_sel, hi, xfer, reg_wr, last;
  assign reg_sel = CPU_A == 16'hFF46;
  assign hi      = (CPU_A[15:8] == 8'hFF) & ~reg_sel;
  assign xfer    = state_q == XFER;
  assign reg_wr  = CPU_WR & reg_sel;
  assign last    = xfer & (idx_q == 8'd159);
`ifdef OAM_DMA_ECHO_FOLD_EN
  assign src_eff = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;
`else
  assign src_eff = src_q;
`endif
  assign BUS_A      = xfer ? {src_eff, idx_q} : CPU_A;
  assign BUS_RD     = xfer | (CPU_RD & ~hi & ~reg_sel);
  assign BUS_WR     = ~xfer & CPU_WR & ~hi & ~reg_sel;
  assign HI_RD      = CPU_RD & hi;
  assign HI_WR      = CPU_WR & hi;
  assign CPU_DI     = reg_sel ? src_q : hi ? HI_DI : xfer ? 8'hFF : BUS_DI;
  assign DMA_ACTIVE = state_q != IDLE;
  assign OAM_WE     = pend_q;
  assign OAM_A      = oam_a_q;
  assign OAM_D      = data_q;
  // The OAM write for a read issued in the restart cycle still lands, since pend/data track XFER, not the FF46 write.
  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      state_q <= IDLE;
      src_q   <= 8'hFF;
      idx_q   <= 8'd0;
      pend_q  <= 1'b0;
      oam_a_q <= 8'd0;
      data_q  <= 8'd0;
    end else begin
      pend_q  <= xfer;
      oam_a_q <= xfer ? idx_q : oam_a_q;
      data_q  <= xfer ? BUS_DI : data_q;
      src_q   <= reg_wr ? CPU_DO : src_q;
      idx_q   <= (reg_wr | ~xfer | last) ? 8'd0 : idx_q + 8'd1;
      state_q <= reg_wr ? DELAY : (state_q == DELAY) ? XFER : (xfer & ~last) ? XFER : IDLE;
    end
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed self-checking bench for oam_dma_ctrl.
module tb_oam_dma_ctrl;
  logic        clk = 1'b0, rst;
  logic [15:0] cpu_a, bus_a;
  logic [7:0]  cpu_do, cpu_di, bus_di, hi_di, oam_a, oam_d;
  logic        cpu_rd, cpu_wr, bus_rd, bus_wr, hi_rd, hi_wr, oam_we, dma_active;
  int vec = 0, err = 0;

  oam_dma_ctrl dut (
    .CLK(clk), .SYNC_RESET(rst), .CPU_A(cpu_a), .CPU_DO(cpu_do), .CPU_RD(cpu_rd), .CPU_WR(cpu_wr),
    .CPU_DI(cpu_di), .BUS_A(bus_a), .BUS_RD(bus_rd), .BUS_WR(bus_wr), .BUS_DI(bus_di),
    .HI_RD(hi_rd), .HI_WR(hi_wr), .HI_DI(hi_di), .OAM_A(oam_a), .OAM_D(oam_d), .OAM_WE(oam_we),
    .DMA_ACTIVE(dma_active)
  );

  always #5 clk = ~clk;

  // Memory image: 0xC1nn = nn ^ 0x5A, other pages differ by their page byte.
  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [7:0] lo, pg;
    lo = a[7:0];
    pg = a[15:8];
    return lo ^ pg ^ 8'h9B;
  endfunction

  always_comb bus_di = mem(bus_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_a = 16'h0000; cpu_do = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic ff46_wr(input logic [7:0] v);
    cpu_a = 16'hFF46; cpu_do = v; cpu_wr = 1'b1; cpu_rd = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && dma_active; i++) tick();
    vec++;
    if (dma_active !== 1'b0) begin err++; $display("FAIL wait_idle: DMA_ACTIVE=%b required 0 within 300 cycles", dma_active); end
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    vec++; if (oam_we !== 1'b0) begin err++; $display("FAIL rst_oam_we: got %b want 0", oam_we); end
    vec++; if (oam_a !== 8'h00) begin err++; $display("FAIL rst_oam_a: got %h want 00", oam_a); end
    vec++; if (oam_d !== 8'h00) begin err++; $display("FAIL rst_oam_d: got %h want 00", oam_d); end
    vec++; if (dma_active !== 1'b0) begin err++; $display("FAIL rst_active: got %b want 0", dma_active); end
    vec++; if ({bus_rd, bus_wr, hi_rd, hi_wr} !== 4'b0000) begin err++; $display("FAIL rst_strobes: got %b want 0000", {bus_rd, bus_wr, hi_rd, hi_wr}); end
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    vec++; if (cpu_di !== 8'hFF) begin err++; $display("FAIL rst_ff46: got %h want FF", cpu_di); end
    vec++; if ({bus_rd, hi_rd} !== 2'b00) begin err++; $display("FAIL rst_ff46_strobes: got %b want 00", {bus_rd, hi_rd}); end
    idle_in();
  endtask

  task automatic test_basic_copy();
    int wes;
    wes = 0;
    ff46_wr(8'hC1);
    for (int c = 1; c <= 164; c++) begin
      tick();
      idle_in();
      #1;
      vec++; if (dma_active !== (c >= 1 && c <= 161)) begin err++; $display("FAIL basic_active c=%0d: got %b", c, dma_active); end
      if (c >= 2 && c <= 161) begin
        vec++; if (bus_a !== (16'hC100 + 16'(c - 2)) || bus_rd !== 1'b1) begin err++; $display("FAIL basic_bus c=%0d: got %h rd=%b want %h rd=1", c, bus_a, bus_rd, 16'hC100 + 16'(c - 2)); end
      end
      vec++; if (oam_we !== (c >= 3 && c <= 162)) begin err++; $display("FAIL basic_we c=%0d: got %b", c, oam_we); end
      if (oam_we) begin
        vec++; if (oam_a !== 8'(c - 3) || oam_d !== (8'(c - 3) ^ 8'h5A)) begin err++; $display("FAIL basic_oam c=%0d: got a=%h d=%h want a=%h d=%h", c, oam_a, oam_d, 8'(c - 3), 8'(c - 3) ^ 8'h5A); end
        wes++;
      end
    end
    vec++; if (wes != 160) begin err++; $display("FAIL basic_count: got %0d want 160", wes); end
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    vec++; if (cpu_di !== 8'hC1) begin err++; $display("FAIL basic_ff46: got %h want C1", cpu_di); end
    idle_in();
  endtask

  task automatic test_fencing();
    ff46_wr(8'hC2);
    tick();
    cpu_a = 16'h8000; cpu_rd = 1'b1; cpu_wr = 1'b0; #1;
    vec++; if (bus_a !== 16'h8000 || cpu_di !== mem(16'h8000)) begin err++; $display("FAIL fence_delay_pass: got a=%h di=%h want 8000 %h", bus_a, cpu_di, mem(16'h8000)); end
    tick();
    #1;
    vec++; if (cpu_di !== 8'hFF) begin err++; $display("FAIL fence_rd: got %h want FF", cpu_di); end
    vec++; if (bus_a !== 16'hC200 || bus_rd !== 1'b1) begin err++; $display("FAIL fence_bus0: got %h rd=%b want C200 rd=1", bus_a, bus_rd); end
    tick();
    cpu_a = 16'hC000; cpu_do = 8'hAA; cpu_rd = 1'b0; cpu_wr = 1'b1; #1;
    vec++; if (bus_wr !== 1'b0 || hi_wr !== 1'b0) begin err++; $display("FAIL fence_wr: got bus_wr=%b hi_wr=%b want 0 0", bus_wr, hi_wr); end
    tick();
    cpu_a = 16'hFF80; hi_di = 8'h3C; cpu_rd = 1'b1; cpu_wr = 1'b0; #1;
    vec++; if (hi_rd !== 1'b1 || cpu_di !== 8'h3C) begin err++; $display("FAIL fence_hi_rd: got hi_rd=%b di=%h want 1 3C", hi_rd, cpu_di); end
    vec++; if (bus_a !== 16'hC202) begin err++; $display("FAIL fence_bus2: got %h want C202", bus_a); end
    tick();
    cpu_a = 16'hFF81; cpu_rd = 1'b0; cpu_wr = 1'b1; #1;
    vec++; if (hi_wr !== 1'b1 || bus_wr !== 1'b0) begin err++; $display("FAIL fence_hi_wr: got hi_wr=%b bus_wr=%b want 1 0", hi_wr, bus_wr); end
    tick();
    idle_in();
    wait_idle();
  endtask

  task automatic test_restart();
    int wes;
    logic [7:0] sp;
    wes = 0;
    ff46_wr(8'hC0);
    for (int c = 1; c <= 216; c++) begin
      tick();
      idle_in();
      if (c == 52) ff46_wr(8'hD0);
      if (c == 53) cpu_a = 16'h1234;
      #1;
      if (c == 52) begin
        vec++; if (bus_a !== 16'hC032) begin err++; $display("FAIL restart_t: got %h want C032", bus_a); end
      end
      if (c == 53) begin
        vec++; if (dma_active !== 1'b1 || bus_a !== 16'h1234 || bus_rd !== 1'b0) begin err++; $display("FAIL restart_delay: got act=%b a=%h rd=%b want 1 1234 0", dma_active, bus_a, bus_rd); end
        vec++; if (oam_we !== 1'b1 || oam_a !== 8'd50 || oam_d !== mem(16'hC032)) begin err++; $display("FAIL restart_last_wr: got we=%b a=%h d=%h want 1 32 %h", oam_we, oam_a, oam_d, mem(16'hC032)); end
      end
      if (c == 54) begin
        vec++; if (bus_a !== 16'hD000 || bus_rd !== 1'b1 || oam_we !== 1'b0) begin err++; $display("FAIL restart_new: got a=%h rd=%b we=%b want D000 1 0", bus_a, bus_rd, oam_we); end
      end
      if (oam_we) begin
        sp = (c <= 53) ? 8'hC0 : 8'hD0;
        vec++; if (oam_d !== mem({sp, oam_a})) begin err++; $display("FAIL restart_oam c=%0d: got %h want %h", c, oam_d, mem({sp, oam_a})); end
        wes++;
      end
    end
    vec++; if (wes != 211) begin err++; $display("FAIL restart_count: got %0d want 211", wes); end
    vec++; if (dma_active !== 1'b0) begin err++; $display("FAIL restart_end: got %b want 0", dma_active); end
  endtask

  task automatic test_reset_mid();
    ff46_wr(8'hC5);
    for (int c = 1; c <= 12; c++) begin tick(); idle_in(); end
    #1;
    vec++; if (bus_a !== 16'hC50A || oam_we !== 1'b1) begin err++; $display("FAIL rstmid_pre: got a=%h we=%b want C50A 1", bus_a, oam_we); end
    rst = 1'b1;
    ff46_wr(8'h77);
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    vec++; if (oam_we !== 1'b0 || dma_active !== 1'b0) begin err++; $display("FAIL rstmid_post: got we=%b act=%b want 0 0", oam_we, dma_active); end
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    vec++; if (cpu_di !== 8'hFF) begin err++; $display("FAIL rstmid_ff46: got %h want FF", cpu_di); end
    tick();
    cpu_a = 16'hC000; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_do = 8'h11; #1;
    vec++; if (bus_wr !== 1'b1 || bus_a !== 16'hC000 || dma_active !== 1'b0) begin err++; $display("FAIL rstmid_wr: got wr=%b a=%h act=%b want 1 C000 0", bus_wr, bus_a, dma_active); end
    tick();
    idle_in();
  endtask

  task automatic test_echo_fold();
    logic [15:0] exp_a;
`ifdef OAM_DMA_ECHO_FOLD_EN
    exp_a = 16'hC300;
`else
    exp_a = 16'hE300;
`endif
    ff46_wr(8'hE3);
    tick(); idle_in();
    tick();
    #1;
    vec++; if (bus_a !== exp_a) begin err++; $display("FAIL echo_bus: got %h want %h", bus_a, exp_a); end
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    vec++; if (cpu_di !== 8'hE3) begin err++; $display("FAIL echo_ff46: got %h want E3", cpu_di); end
    tick();
    idle_in();
    #1;
    vec++; if (bus_a !== exp_a + 16'd1) begin err++; $display("FAIL echo_bus1: got %h want %h", bus_a, exp_a + 16'd1); end
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; hi_di = 8'h00;
    idle_in();
    test_reset();
    test_basic_copy();
    test_fencing();
    test_restart();
    test_reset_mid();
    test_echo_fold();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
